multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the phase-2 CPU. Replaces the single-cycle opcode decoder by sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same datapath controls: regdst, alusrc, aluop, regwrite, memread, memwrite, memreg and branch.
- Adds PC/IR write enables, a memory-ready handshake with timeout, halt handling and a retired-instruction counter.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles with mem_ready low in FETCH or MEM before a fault is declared (range 1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  instruction opcode field from the IR. Sampled in DECODE.
- mem_ready  in  1  memory access completes this cycle (shared by the instruction and data memory).
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load the IR.
- pc_write  out  1  update the PC.
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- branch  out  1  branch instruction in EXEC.
- regdst  out  1  destination is the rd field.
- alusrc  out  1  ALU B operand is the immediate.
- aluop  out  3  ALU operation.
- regwrite  out  1  register file write.
- memread  out  1  data memory read.
- memwrite  out  1  data memory write.
- memreg  out  1  writeback selects memory data.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  out  1  FSM is in HALT.
- mem_error  out  1  sticky memory-timeout fault.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH, op_q=0, wait_cnt=0, retired=0, mem_error=0.
  - All outputs are 0, with state=0. Strobes are gated by rst_n.
  - First active cycle after release is FETCH.
  - Reset mid-instruction abandons it with no partial count.
- Outputs are Moore: decoded from state and op_q, where op_q is opcode latched at the end of DECODE.
  - Exception: in DECODE, decode uses the live opcode.
- Opcode map and aluop:
  - 0: R-type, aluop=0 (funct-driven).
  - 1..7: immediate ALU op, aluop=opcode.
  - 8: load, aluop=1 (add).
  - 9: store, aluop=1.
  - 10: beq, aluop=2 (sub).
  - 11: jump.
  - 15: halt.
  - 12..14: nop.
- FETCH: imem_req=1.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch op_q.
  - Jump: pc_write=1, pc_src=2, retire, go to FETCH.
  - Halt: go to HALT (not counted).
  - Nop: retire, go to FETCH.
  - Else: go to EXEC.
- EXEC: drive alusrc (1 for opcodes 1..9) and aluop.
  - R-type/imm: go to WB.
  - Load/store: go to MEM.
  - Beq: branch=1. pc_write=alu_zero, pc_src=1. Retire, go to FETCH.
- MEM: load: memread=1; store: memwrite=1; both with alusrc=1, aluop=1.
  - Held until mem_ready=1.
  - Then load goes to WB; store retires and goes to FETCH.
- WB: regwrite=1.
  - regdst=1 only for R-type.
  - memreg=1 only for load.
  - Retire, go to FETCH.
- Cycle counts with mem_ready tied high:
  - R/imm: 4.
  - Load: 5.
  - Store: 4.
  - Beq: 3.
  - Jump/nop: 2.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM.
  - It increments each cycle mem_ready=0 in those states.
  - If wait_cnt==MEM_WAIT_MAX and mem_ready=0: set mem_error=1 and go to HALT.
  - mem_ready=1 on the final cycle is accepted normally.
- HALT is absorbing until reset. halted=1 and all strobes are 0.
- retired increments by 1 on each retire event and wraps from 2^CNT_W-1 to 0.
- Strobes are never asserted outside their named state.
- memread and memwrite are never both 1.

Test Plan:
- Reset, then R-type (opcode=0), mem_ready=1 -> state 0,1,2,4,0. regwrite=1 and regdst=1 only in WB. retired=1 after 4 cycles.
- Load (8) with mem_ready low for 3 MEM cycles -> memread=1 held 4 cycles. Then WB with memreg=1, regwrite=1. Total 8 cycles, retired +1.
- Beq (10): alu_zero=1 -> pc_write=1, pc_src=1 in EXEC. Repeat with alu_zero=0 -> pc_write=0. Each takes 3 cycles.
- Jump (11) -> pc_write=1, pc_src=2 in DECODE. Back in FETCH next cycle.
- mem_ready held 0 in FETCH -> after MEM_WAIT_MAX+1=16 cycles mem_error=1, halted=1, state=5. Further mem_ready is ignored.
- Halt (15) -> halted=1 and retired unchanged. Assert rst_n low mid-EXEC of a store -> all outputs 0 immediately. Release -> FETCH.
- CNT_W=4, 16 nops -> retired wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath strobes, PC/IR enables, memory timeout and retire counter.
`timescale 1ns/1ps
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             branch,
  output logic             regdst,
  output logic             alusrc,
  output logic [2:0]       aluop,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             memreg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_error_q, mem_error_d;

  logic       imem_req_raw, ir_write_raw, pc_write_raw, branch_raw, regdst_raw;
  logic       alusrc_raw, regwrite_raw, memread_raw, memwrite_raw, memreg_raw;
  logic [1:0] pc_src_raw;
  logic [2:0] aluop_raw;
  logic       retire;

  // DECODE has not latched the opcode yet, so it looks at the IR field directly.
  logic [3:0] dec_op;
  logic       is_rtype, is_imm, is_load, is_store, is_beq, is_jump, is_halt, is_nop;
  logic       mem_timeout;

  assign dec_op      = (state_q == S_DECODE) ? opcode : op_q;
  assign is_rtype    = (dec_op == 4'd0);
  assign is_imm      = (dec_op inside {[4'd1:4'd7]});
  assign is_load     = (dec_op == 4'd8);
  assign is_store    = (dec_op == 4'd9);
  assign is_beq      = (dec_op == 4'd10);
  assign is_jump     = (dec_op == 4'd11);
  assign is_halt     = (dec_op == 4'd15);
  assign is_nop      = (dec_op inside {[4'd12:4'd14]});
  assign mem_timeout = (wait_cnt_q == WAIT_MAX) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      op_q        <= 4'd0;
      wait_cnt_q  <= 8'd0;
      retired_q   <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_cnt_q  <= wait_cnt_d;
      retired_q   <= retired_d;
      mem_error_q <= mem_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_cnt_d   = 8'd0;
    mem_error_d  = mem_error_q;
    retire       = 1'b0;
    imem_req_raw = 1'b0;
    ir_write_raw = 1'b0;
    pc_write_raw = 1'b0;
    pc_src_raw   = 2'd0;
    branch_raw   = 1'b0;
    regdst_raw   = 1'b0;
    alusrc_raw   = 1'b0;
    aluop_raw    = 3'd0;
    regwrite_raw = 1'b0;
    memread_raw  = 1'b0;
    memwrite_raw = 1'b0;
    memreg_raw   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_raw = 1'b1;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_d      = S_DECODE;
        end else if (mem_timeout) begin
          mem_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (is_jump) begin
          pc_write_raw = 1'b1;
          pc_src_raw   = 2'd2;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_nop) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alusrc_raw = (dec_op inside {[4'd1:4'd9]});
        if (is_imm)                  aluop_raw = dec_op[2:0];
        else if (is_load || is_store) aluop_raw = 3'd1;
        else if (is_beq)             aluop_raw = 3'd2;
        if (is_beq) begin
          branch_raw   = 1'b1;
          pc_write_raw = alu_zero;
          pc_src_raw   = 2'd1;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alusrc_raw   = 1'b1;
        aluop_raw    = 3'd1;
        memread_raw  = is_load;
        memwrite_raw = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (mem_timeout) begin
          mem_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        regwrite_raw = 1'b1;
        regdst_raw   = is_rtype;
        memreg_raw   = is_load;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  // Combinational strobes are forced low while reset is held.
  assign imem_req  = imem_req_raw & rst_n;
  assign ir_write  = ir_write_raw & rst_n;
  assign pc_write  = pc_write_raw & rst_n;
  assign pc_src    = pc_src_raw & {2{rst_n}};
  assign branch    = branch_raw & rst_n;
  assign regdst    = regdst_raw & rst_n;
  assign alusrc    = alusrc_raw & rst_n;
  assign aluop     = aluop_raw & {3{rst_n}};
  assign regwrite  = regwrite_raw & rst_n;
  assign memread   = memread_raw & rst_n;
  assign memwrite  = memwrite_raw & rst_n;
  assign memreg    = memreg_raw & rst_n;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT) & rst_n;
  assign mem_error = mem_error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction cycle plans built from the instruction
// rules, table vectors, random instruction streams and hand-written corner sequences.
`timescale 1ns/1ps
module tb_multicycle_sequencer;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_H = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic mem_ready = 1'b0;
  logic alu_zero = 1'b0;

  logic imem_req, ir_write, pc_write, branch, regdst, alusrc, regwrite;
  logic memread, memwrite, memreg, halted, mem_error;
  logic [1:0] pc_src;
  logic [2:0] aluop, state;
  logic [15:0] retired;

  logic imem_req_n4, ir_write_n4, pc_write_n4, branch_n4, regdst_n4, alusrc_n4, regwrite_n4;
  logic memread_n4, memwrite_n4, memreg_n4, halted_n4, mem_error_n4;
  logic [1:0] pc_src_n4;
  logic [2:0] aluop_n4, state_n4;
  logic [3:0] retired_n4;

  multicycle_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .branch(branch), .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .memreg(memreg), .state(state),
    .halted(halted), .mem_error(mem_error), .retired(retired)
  );

  multicycle_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut_n4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req_n4), .ir_write(ir_write_n4), .pc_write(pc_write_n4), .pc_src(pc_src_n4),
    .branch(branch_n4), .regdst(regdst_n4), .alusrc(alusrc_n4), .aluop(aluop_n4),
    .regwrite(regwrite_n4), .memread(memread_n4), .memwrite(memwrite_n4), .memreg(memreg_n4),
    .state(state_n4), .halted(halted_n4), .mem_error(mem_error_n4), .retired(retired_n4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int model_ret = 0;

  typedef struct {
    int ph;
    bit rdy;
    bit ret;
    bit err;
  } step_t;
  step_t plan[$];

  typedef struct {
    logic [3:0] op;
    bit         z;
    int         exp_cycles;
    int         exp_ret;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] dut_ctrl();
    return {imem_req, ir_write, pc_write, pc_src, branch, regdst, alusrc, aluop,
            regwrite, memread, memwrite, memreg, halted, mem_error};
  endfunction

  function automatic logic [16:0] dut_ctrl_n4();
    return {imem_req_n4, ir_write_n4, pc_write_n4, pc_src_n4, branch_n4, regdst_n4,
            alusrc_n4, aluop_n4, regwrite_n4, memread_n4, memwrite_n4, memreg_n4,
            halted_n4, mem_error_n4};
  endfunction

  // Expected strobes for one cycle of a phase, straight from the instruction rules.
  function automatic logic [16:0] exp_ctrl(input int ph, input int op, input bit rdy,
                                           input bit z, input bit err);
    logic imem, irw, pcw, br, rd, asrc, rw, mr, mw, mreg, hlt;
    logic [1:0] src;
    logic [2:0] aop;
    imem = 0; irw = 0; pcw = 0; br = 0; rd = 0; asrc = 0; rw = 0;
    mr = 0; mw = 0; mreg = 0; hlt = 0; src = 2'd0; aop = 3'd0;
    case (ph)
      PH_F: begin imem = 1; irw = rdy; pcw = rdy; end
      PH_D: if (op == 11) begin pcw = 1; src = 2'd2; end
      PH_E: begin
        asrc = (op >= 1 && op <= 9);
        if (op == 10) begin br = 1; pcw = z; src = 2'd1; aop = 3'd2; end
        else if (op >= 8) aop = 3'd1;
        else aop = 3'(op);
      end
      PH_M: begin asrc = 1; aop = 3'd1; mr = (op == 8); mw = (op == 9); end
      PH_W: begin rw = 1; rd = (op == 0); mreg = (op == 8); end
      PH_H: hlt = 1;
      default: ;
    endcase
    return {imem, irw, pcw, src, br, rd, asrc, aop, rw, mr, mw, mreg, hlt, err};
  endfunction

  function automatic step_t mk(input int ph, input bit rdy, input bit ret, input bit err);
    step_t s;
    s.ph = ph; s.rdy = rdy; s.ret = ret; s.err = err;
    return s;
  endfunction

  function automatic bit rb();
    return 1'($urandom % 2);
  endfunction

  // Cycle-by-cycle phase list of one instruction given fetch and data-memory stall counts.
  task automatic build_plan(input int op, input int fw, input int mw);
    plan.delete();
    repeat (fw) plan.push_back(mk(PH_F, 0, 0, 0));
    plan.push_back(mk(PH_F, 1, 0, 0));
    if (op == 15) begin
      plan.push_back(mk(PH_D, rb(), 0, 0));
      repeat (3) plan.push_back(mk(PH_H, rb(), 0, 0));
    end else if (op >= 11) begin
      plan.push_back(mk(PH_D, rb(), 1, 0));
    end else begin
      plan.push_back(mk(PH_D, rb(), 0, 0));
      if (op == 10) begin
        plan.push_back(mk(PH_E, rb(), 1, 0));
      end else if (op <= 7) begin
        plan.push_back(mk(PH_E, rb(), 0, 0));
        plan.push_back(mk(PH_W, rb(), 1, 0));
      end else begin
        plan.push_back(mk(PH_E, rb(), 0, 0));
        repeat (mw) plan.push_back(mk(PH_M, 0, 0, 0));
        if (op == 8) begin
          plan.push_back(mk(PH_M, 1, 0, 0));
          plan.push_back(mk(PH_W, rb(), 1, 0));
        end else begin
          plan.push_back(mk(PH_M, 1, 1, 0));
        end
      end
    end
  endtask

  // Called #1 after a rising edge; applies the plan and checks every cycle at the falling edge.
  task automatic run_plan(input int op, input bit z, output int cycles, output int delta);
    int nonf;
    logic [15:0] r0, diff;
    nonf = 0;
    r0 = retired;
    for (int i = 0; i < plan.size(); i++) begin
      mem_ready = plan[i].rdy;
      opcode = 4'(op);
      alu_zero = z;
      @(negedge clk);
      if (state != 3'd0) nonf++;
      check($sformatf("state op%0d cyc%0d", op, i), 32'(state), 32'(plan[i].ph));
      check($sformatf("ctrl op%0d cyc%0d", op, i), 32'(dut_ctrl()),
            32'(exp_ctrl(plan[i].ph, op, plan[i].rdy, z, plan[i].err)));
      check($sformatf("retired op%0d cyc%0d", op, i), 32'(retired), 32'(model_ret & 32'hFFFF));
      check($sformatf("n4 ctrl op%0d cyc%0d", op, i), 32'({state_n4, dut_ctrl_n4()}),
            32'({3'(plan[i].ph), exp_ctrl(plan[i].ph, op, plan[i].rdy, z, plan[i].err)}));
      check($sformatf("n4 retired op%0d cyc%0d", op, i), 32'(retired_n4), 32'(model_ret & 32'hF));
      @(posedge clk);
      #1;
      if (plan[i].ret) model_ret++;
    end
    cycles = 1 + nonf;
    diff = retired - r0;
    delta = int'(diff);
  endtask

  task automatic run_instr(input int op, input int fw, input int mw, input bit z,
                           output int cycles, output int delta);
    build_plan(op, fw, mw);
    run_plan(op, z, cycles, delta);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"}, 32'(dut_ctrl()), 32'd0);
    check({tag, " state"}, 32'(state), 32'd0);
    check({tag, " retired"}, 32'(retired), 32'd0);
    check({tag, " n4 outs"}, 32'({state_n4, retired_n4, dut_ctrl_n4()}), 32'd0);
  endtask

  // Holds reset over an edge with mem_ready high so ungated strobes would show up.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 4'd0;
    alu_zero = 1'b1;
    @(negedge clk);
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_ret = 0;
  endtask

  initial begin
    int cyc, dlt;
    vecs[0] = '{4'd0,  1'b0, 4, 1};
    vecs[1] = '{4'd3,  1'b1, 4, 1};
    vecs[2] = '{4'd7,  1'b0, 4, 1};
    vecs[3] = '{4'd8,  1'b0, 5, 1};
    vecs[4] = '{4'd9,  1'b1, 4, 1};
    vecs[5] = '{4'd10, 1'b1, 3, 1};
    vecs[6] = '{4'd10, 1'b0, 3, 1};
    vecs[7] = '{4'd11, 1'b0, 2, 1};
    vecs[8] = '{4'd12, 1'b1, 2, 1};
    vecs[9] = '{4'd14, 1'b0, 2, 1};

    #2;
    do_reset("reset");

    // Table vectors with mem_ready high throughout.
    foreach (vecs[v]) begin
      run_instr(int'(vecs[v].op), 0, 0, vecs[v].z, cyc, dlt);
      check($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      check($sformatf("vec%0d retire delta", v), 32'(dlt), 32'(vecs[v].exp_ret));
    end

    // Load with three stalled MEM cycles: 8 cycles in total.
    run_instr(8, 0, 3, 1'b0, cyc, dlt);
    check("load stall cycles", 32'(cyc), 32'd8);
    check("load stall delta", 32'(dlt), 32'd1);

    // Ready arriving on the last permitted stall cycle is still accepted.
    run_instr(0, 15, 0, 1'b0, cyc, dlt);
    check("fetch 15 stall delta", 32'(dlt), 32'd1);
    run_instr(8, 0, 15, 1'b1, cyc, dlt);
    check("mem 15 stall delta", 32'(dlt), 32'd1);

    for (int n = 0; n < 60; n++) begin
      int op, fw, mw;
      op = int'($urandom_range(0, 14));
      fw = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : 0;
      mw = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : 0;
      run_instr(op, fw, mw, rb(), cyc, dlt);
    end

    // Halt instruction: absorbing, not counted.
    run_instr(15, int'($urandom_range(0, 2)), 0, 1'b0, cyc, dlt);
    check("halt retire delta", 32'(dlt), 32'd0);

    do_reset("reset after halt");
    run_instr(0, 0, 0, 1'b0, cyc, dlt);

    // Reset asserted in the middle of a store's EXEC cycle.
    opcode = 4'd9;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("store in exec", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset mid exec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 0;
    run_instr(12, 0, 0, 1'b0, cyc, dlt);
    check("after mid reset delta", 32'(dlt), 32'd1);

    // Fetch timeout: 16 stalled cycles then sticky fault in HALT.
    do_reset("reset before fetch timeout");
    plan.delete();
    repeat (16) plan.push_back(mk(PH_F, 0, 0, 0));
    repeat (4) plan.push_back(mk(PH_H, rb(), 0, 1));
    run_plan(0, 1'b0, cyc, dlt);
    check("fetch timeout delta", 32'(dlt), 32'd0);

    // Data-memory timeout during a load.
    do_reset("reset before mem timeout");
    plan.delete();
    plan.push_back(mk(PH_F, 1, 0, 0));
    plan.push_back(mk(PH_D, 1, 0, 0));
    plan.push_back(mk(PH_E, 1, 0, 0));
    repeat (16) plan.push_back(mk(PH_M, 0, 0, 0));
    repeat (3) plan.push_back(mk(PH_H, 1, 0, 1));
    run_plan(8, 1'b0, cyc, dlt);
    check("mem timeout delta", 32'(dlt), 32'd0);

    // Counter wrap on the 4-bit instance after 16 nops.
    do_reset("reset before wrap");
    for (int n = 0; n < 16; n++) begin
      run_instr(12 + (n % 3), 0, 0, 1'b0, cyc, dlt);
      if (n == 14) check("n4 retired at 15", 32'(retired_n4), 32'd15);
    end
    check("n4 retired wrapped", 32'(retired_n4), 32'd0);
    check("retired 16-bit after 16", 32'(retired), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
